// File: rtl/online_ca_gen_v3.sv
// On-the-fly operand-vector generator for the online (MSD-first) multiplier: borrow-save digits
// are accumulated into left-aligned vectors and stored per step in a masked row RAM.
// Optional build macro ONLINE_CA_XDELAY_EN adds an enable-gated delay register on the X read path.
module online_ca_gen_v3 #(
  parameter int UNROLLING  = 64,
  parameter int ADDR_WIDTH = 7,
  parameter int IDX_WIDTH  = 7
) (
  input  logic                  clk,
  input  logic                  asyn_reset,
  input  logic                  enable,
  input  logic                  start,
  input  logic [1:0]            x_in,
  input  logic [1:0]            y_in,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [UNROLLING-1:0]  x_plus_dis,
  output logic [UNROLLING-1:0]  x_minus_dis,
  output logic [UNROLLING-1:0]  y_plus_rd,
  output logic [UNROLLING-1:0]  y_minus_rd,
  output logic [IDX_WIDTH-1:0]  digit_idx,
  output logic                  overflow,
  output logic                  bad_digit
);

  localparam int DEPTH = 2**ADDR_WIDTH;
  localparam logic [IDX_WIDTH-1:0] IDX_LAST = IDX_WIDTH'(UNROLLING-1);

  typedef enum logic [1:0] {ACT_IDLE, ACT_START, ACT_SHIFT, ACT_DROP} act_t;

  // Stage 0: input register
  logic                  v_q;
  logic                  start_q;
  logic [1:0]            x_q;
  logic [1:0]            y_q;
  logic [ADDR_WIDTH-1:0] wr_addr_q;
  logic                  bad_q;

  // Stage 1: accumulated vectors and bookkeeping
  logic [UNROLLING-1:0]  xp_vec, xm_vec, yp_vec, ym_vec;
  logic [UNROLLING-1:0]  xp_nxt, xm_nxt, yp_nxt, ym_nxt;
  logic [IDX_WIDTH-1:0]  idx, idx_nxt;
  logic                  ovf;
  logic [DEPTH-1:0]      row_vld, row_vld_nxt;
  act_t                  act;

  // Row RAM and read path
  logic [4*UNROLLING-1:0] mem [DEPTH];
  logic                   wr_en;
  logic [IDX_WIDTH-1:0]   shamt;
  logic [4*UNROLLING-1:0] wr_data;
  logic [4*UNROLLING-1:0] rd_row;
  logic [UNROLLING-1:0]   x_plus_rd, x_minus_rd;

  always_ff @(posedge clk or posedge asyn_reset) begin
    if (asyn_reset) begin
      v_q       <= 1'b0;
      start_q   <= 1'b0;
      x_q       <= '0;
      y_q       <= '0;
      wr_addr_q <= '0;
      bad_q     <= 1'b0;
    end else begin
      v_q   <= enable;
      bad_q <= enable & ((x_in == 2'b11) | (y_in == 2'b11));
      if (enable) begin
        start_q   <= start;
        x_q       <= (x_in == 2'b11) ? 2'b00 : x_in;
        y_q       <= (y_in == 2'b11) ? 2'b00 : y_in;
        wr_addr_q <= wr_addr;
      end
    end
  end

  always_comb begin
    if (!v_q)                act = ACT_IDLE;
    else if (start_q)        act = ACT_START;
    else if (idx == IDX_LAST) act = ACT_DROP;
    else                     act = ACT_SHIFT;
  end

  always_comb begin
    xp_nxt      = xp_vec;
    xm_nxt      = xm_vec;
    yp_nxt      = yp_vec;
    ym_nxt      = ym_vec;
    idx_nxt     = idx;
    row_vld_nxt = row_vld;
    case (act)
      ACT_START: begin
        xp_nxt      = {{(UNROLLING-1){1'b0}}, x_q[1]};
        xm_nxt      = {{(UNROLLING-1){1'b0}}, x_q[0]};
        yp_nxt      = {{(UNROLLING-1){1'b0}}, y_q[1]};
        ym_nxt      = {{(UNROLLING-1){1'b0}}, y_q[0]};
        idx_nxt     = '0;
        row_vld_nxt = '0;
        row_vld_nxt[wr_addr_q] = 1'b1;
      end
      ACT_SHIFT: begin
        xp_nxt  = {xp_vec[UNROLLING-2:0], x_q[1]};
        xm_nxt  = {xm_vec[UNROLLING-2:0], x_q[0]};
        yp_nxt  = {yp_vec[UNROLLING-2:0], y_q[1]};
        ym_nxt  = {ym_vec[UNROLLING-2:0], y_q[0]};
        idx_nxt = idx + 1'b1;
        row_vld_nxt[wr_addr_q] = 1'b1;
      end
      default: ;
    endcase
  end

  // Row image puts the most significant digit at bit UNROLLING-1
  assign wr_en   = (act == ACT_START) || (act == ACT_SHIFT);
  assign shamt   = IDX_LAST - idx_nxt;
  assign wr_data = {xp_nxt << shamt, xm_nxt << shamt, yp_nxt << shamt, ym_nxt << shamt};

  always_ff @(posedge clk or posedge asyn_reset) begin
    if (asyn_reset) begin
      xp_vec  <= '0;
      xm_vec  <= '0;
      yp_vec  <= '0;
      ym_vec  <= '0;
      idx     <= '0;
      ovf     <= 1'b0;
      row_vld <= '0;
    end else begin
      xp_vec  <= xp_nxt;
      xm_vec  <= xm_nxt;
      yp_vec  <= yp_nxt;
      ym_vec  <= ym_nxt;
      idx     <= idx_nxt;
      row_vld <= row_vld_nxt;
      if (act == ACT_START)     ovf <= 1'b0;
      else if (act == ACT_DROP) ovf <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr_q] <= wr_data;
  end

  // Write-first bypass; validity comes from the post-update mask so a start hides stale rows
  assign rd_row = (wr_en && (wr_addr_q == rd_addr)) ? wr_data : mem[rd_addr];

  always_ff @(posedge clk or posedge asyn_reset) begin
    if (asyn_reset) begin
      x_plus_rd  <= '0;
      x_minus_rd <= '0;
      y_plus_rd  <= '0;
      y_minus_rd <= '0;
    end else if (rd_en) begin
      if (row_vld_nxt[rd_addr]) begin
        {x_plus_rd, x_minus_rd, y_plus_rd, y_minus_rd} <= rd_row;
      end else begin
        {x_plus_rd, x_minus_rd, y_plus_rd, y_minus_rd} <= '0;
      end
    end
  end

`ifdef ONLINE_CA_XDELAY_EN
  logic [UNROLLING-1:0] xd_plus, xd_minus;

  always_ff @(posedge clk or posedge asyn_reset) begin
    if (asyn_reset) begin
      xd_plus  <= '0;
      xd_minus <= '0;
    end else if (enable) begin
      xd_plus  <= x_plus_rd;
      xd_minus <= x_minus_rd;
    end
  end

  assign x_plus_dis  = enable ? xd_plus  : x_plus_rd;
  assign x_minus_dis = enable ? xd_minus : x_minus_rd;
`else
  assign x_plus_dis  = x_plus_rd;
  assign x_minus_dis = x_minus_rd;
`endif

  assign digit_idx = idx;
  assign overflow  = ovf;
  assign bad_digit = bad_q;

endmodule

// File: tb/tb_online_ca_gen_v3.sv
// Scoreboard bench for online_ca_gen_v3 (UNROLLING=8): a digit-list reference model predicts
// per-cycle outputs; a negedge monitor pops and compares them.
module tb_online_ca_gen_v3;
  localparam int U     = 8;
  localparam int AW    = 4;
  localparam int IW    = 4;
  localparam int DEPTH = 2**AW;

  logic          clk = 1'b0;
  logic          asyn_reset = 1'b1;
  logic          enable = 1'b0, start = 1'b0, rd_en = 1'b0;
  logic [1:0]    x_in = '0, y_in = '0;
  logic [AW-1:0] wr_addr = '0, rd_addr = '0;
  logic [U-1:0]  x_plus_dis, x_minus_dis, y_plus_rd, y_minus_rd;
  logic [IW-1:0] digit_idx;
  logic          overflow, bad_digit;

  online_ca_gen_v3 #(.UNROLLING(U), .ADDR_WIDTH(AW), .IDX_WIDTH(IW)) dut (
    .clk(clk), .asyn_reset(asyn_reset), .enable(enable), .start(start),
    .x_in(x_in), .y_in(y_in), .wr_addr(wr_addr), .rd_en(rd_en), .rd_addr(rd_addr),
    .x_plus_dis(x_plus_dis), .x_minus_dis(x_minus_dis),
    .y_plus_rd(y_plus_rd), .y_minus_rd(y_minus_rd),
    .digit_idx(digit_idx), .overflow(overflow), .bad_digit(bad_digit)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    logic [U-1:0]  xp, xm, yp, ym, xdp, xdm;
    logic [IW-1:0] idx;
    logic          ovf, bad;
  } rec_t;
  rec_t exp_q[$];

  // Reference model: the accepted digits of the current operand, in arrival order
  bit           xpq[$], xmq[$], ypq[$], ymq[$];
  logic [U-1:0] m_xp[DEPTH], m_xm[DEPTH], m_yp[DEPTH], m_ym[DEPTH];
  bit           vld_m[DEPTH];
  logic [U-1:0] r_xp, r_xm, r_yp, r_ym, xd_p, xd_m;
  bit           ovf_m, bad_m;
  bit           pend_v, pend_st;
  logic [1:0]   pend_x, pend_y;
  logic [AW-1:0] pend_a;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Digit j of the operand occupies bit U-1-j
  function automatic logic [U-1:0] row_of(input bit q[$]);
    logic [U-1:0] v = '0;
    for (int j = 0; j < q.size(); j++) v[U-1-j] = q[j];
    return v;
  endfunction

  task automatic model_reset();
    xpq.delete(); xmq.delete(); ypq.delete(); ymq.delete();
    for (int i = 0; i < DEPTH; i++) vld_m[i] = 1'b0;
    r_xp = '0; r_xm = '0; r_yp = '0; r_ym = '0; xd_p = '0; xd_m = '0;
    ovf_m = 1'b0; bad_m = 1'b0; pend_v = 1'b0;
  endtask

  task automatic model_edge(input bit en, input bit st, input logic [1:0] x, input logic [1:0] y,
                            input logic [AW-1:0] wa, input bit re, input logic [AW-1:0] ra);
    rec_t r;
    logic [1:0] xd, yd;
    bit wr;
    if (pend_v) begin
      xd = (pend_x == 2'b11) ? 2'b00 : pend_x;
      yd = (pend_y == 2'b11) ? 2'b00 : pend_y;
      wr = 1'b1;
      if (pend_st) begin
        xpq.delete(); xmq.delete(); ypq.delete(); ymq.delete();
        for (int i = 0; i < DEPTH; i++) vld_m[i] = 1'b0;
        ovf_m = 1'b0;
      end else if (xpq.size() >= U) begin
        ovf_m = 1'b1;
        wr = 1'b0;
      end
      if (wr) begin
        xpq.push_back(xd[1]); xmq.push_back(xd[0]);
        ypq.push_back(yd[1]); ymq.push_back(yd[0]);
        vld_m[pend_a] = 1'b1;
        m_xp[pend_a] = row_of(xpq); m_xm[pend_a] = row_of(xmq);
        m_yp[pend_a] = row_of(ypq); m_ym[pend_a] = row_of(ymq);
      end
    end
    if (en) begin xd_p = r_xp; xd_m = r_xm; end
    if (re) begin
      if (vld_m[ra]) begin r_xp = m_xp[ra]; r_xm = m_xm[ra]; r_yp = m_yp[ra]; r_ym = m_ym[ra]; end
      else begin r_xp = '0; r_xm = '0; r_yp = '0; r_ym = '0; end
    end
    bad_m  = en && (x == 2'b11 || y == 2'b11);
    pend_v = en; pend_st = st; pend_x = x; pend_y = y; pend_a = wa;
    r.xp = r_xp; r.xm = r_xm; r.yp = r_yp; r.ym = r_ym; r.xdp = xd_p; r.xdm = xd_m;
    r.idx = (xpq.size() == 0) ? '0 : IW'(xpq.size() - 1);
    r.ovf = ovf_m; r.bad = bad_m;
    exp_q.push_back(r);
  endtask

  task automatic step(input bit en, input bit st, input logic [1:0] x, input logic [1:0] y,
                      input logic [AW-1:0] wa, input bit re, input logic [AW-1:0] ra);
    enable = en; start = st; x_in = x; y_in = y; wr_addr = wa; rd_en = re; rd_addr = ra;
    @(posedge clk);
    model_edge(en, st, x, y, wa, re, ra);
    #1;
  endtask

  task automatic apply_reset(input string tag);
    @(negedge clk);
    #1 asyn_reset = 1'b1;
    #1;
    chk({tag, "_x_plus"}, 64'(x_plus_dis), 64'd0);
    chk({tag, "_x_minus"}, 64'(x_minus_dis), 64'd0);
    chk({tag, "_y_plus"}, 64'(y_plus_rd), 64'd0);
    chk({tag, "_y_minus"}, 64'(y_minus_rd), 64'd0);
    chk({tag, "_idx"}, 64'(digit_idx), 64'd0);
    chk({tag, "_ovf"}, 64'(overflow), 64'd0);
    chk({tag, "_bad"}, 64'(bad_digit), 64'd0);
    model_reset();
    #1 asyn_reset = 1'b0;
  endtask

  // Monitor: one expected record per clock edge, compared at the following negedge
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      rec_t r;
      logic [U-1:0] exp_xp, exp_xm;
      r = exp_q.pop_front();
`ifdef ONLINE_CA_XDELAY_EN
      exp_xp = enable ? r.xdp : r.xp;
      exp_xm = enable ? r.xdm : r.xm;
`else
      exp_xp = r.xp;
      exp_xm = r.xm;
`endif
      chk("x_plus_dis", 64'(x_plus_dis), 64'(exp_xp));
      chk("x_minus_dis", 64'(x_minus_dis), 64'(exp_xm));
      chk("y_plus_rd", 64'(y_plus_rd), 64'(r.yp));
      chk("y_minus_rd", 64'(y_minus_rd), 64'(r.ym));
      chk("digit_idx", 64'(digit_idx), 64'(r.idx));
      chk("overflow", 64'(overflow), 64'(r.ovf));
      chk("bad_digit", 64'(bad_digit), 64'(r.bad));
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bit need_start;
    model_reset();
    apply_reset("reset");

    // +1,-1,0,+1 into rows 0..3, then read row 3 on the write edge
    step(1, 1, 2'b10, 2'b10, 4'd0, 0, 4'd0);
    step(1, 0, 2'b01, 2'b01, 4'd1, 0, 4'd0);
    step(1, 0, 2'b00, 2'b00, 4'd2, 0, 4'd0);
    step(1, 0, 2'b10, 2'b10, 4'd3, 0, 4'd0);
    step(0, 0, 2'b00, 2'b00, 4'd0, 1, 4'd3);
    chk("plan_y_plus", 64'(y_plus_rd), 64'h90);
    chk("plan_y_minus", 64'(y_minus_rd), 64'h40);
    chk("plan_idx", 64'(digit_idx), 64'd3);

    step(0, 0, 2'b00, 2'b00, 4'd0, 1, 4'd5);
    chk("unwritten_row", 64'({y_plus_rd, y_minus_rd}), 64'd0);

    // New start hides stale row 2 on the same edge
    step(1, 1, 2'b10, 2'b01, 4'd7, 0, 4'd0);
    step(0, 0, 2'b00, 2'b00, 4'd0, 1, 4'd2);
    chk("stale_row", 64'({y_plus_rd, y_minus_rd}), 64'd0);

    // Eight more digits: the ninth overall is dropped
    for (int i = 0; i < 8; i++)
      step(1, 0, 2'(i % 3), 2'((i + 1) % 3), 4'(8 + i), 0, 4'd0);
    step(0, 0, 2'b00, 2'b00, 4'd0, 1, 4'd15);
    step(0, 0, 2'b00, 2'b00, 4'd0, 1, 4'd14);
    chk("ovf_set", 64'(overflow), 64'd1);
    chk("ovf_idx", 64'(digit_idx), 64'd7);
    step(1, 1, 2'b01, 2'b10, 4'd0, 0, 4'd0);
    step(0, 0, 2'b00, 2'b00, 4'd0, 0, 4'd0);
    chk("ovf_clear", 64'(overflow), 64'd0);

    // Invalid digit, then read the row it landed in
    step(1, 0, 2'b11, 2'b10, 4'd1, 0, 4'd0);
    chk("bad_pulse", 64'(bad_digit), 64'd1);
    step(0, 0, 2'b00, 2'b00, 4'd0, 1, 4'd1);
    chk("bad_clear", 64'(bad_digit), 64'd0);

    // Mid-operand asynchronous reset with a digit in flight
    step(1, 1, 2'b10, 2'b10, 4'd4, 0, 4'd0);
    step(1, 0, 2'b01, 2'b10, 4'd5, 0, 4'd0);
    apply_reset("midreset");
    step(0, 0, 2'b00, 2'b00, 4'd0, 1, 4'd4);
    chk("post_reset_read", 64'({y_plus_rd, y_minus_rd}), 64'd0);

    need_start = 1'b1;
    for (int n = 0; n < 600; n++) begin
      bit en, st, re;
      en = ($urandom_range(0, 3) != 0);
      st = ($urandom_range(0, 11) == 0) || need_start;
      if (!en) st = 1'b0;
      if (en && st) need_start = 1'b0;
      re = ($urandom_range(0, 1) == 1);
      step(en, st, 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
           AW'($urandom_range(0, DEPTH - 1)), re, AW'($urandom_range(0, DEPTH - 1)));
      if (n == 300) begin
        apply_reset("rand_reset");
        need_start = 1'b1;
      end
    end

    step(0, 0, 2'b00, 2'b00, 4'd0, 0, 4'd0);
    step(0, 0, 2'b00, 2'b00, 4'd0, 0, 4'd0);
    for (int w = 0; w < 10 && exp_q.size() > 0; w++) @(negedge clk);
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
